seg7_capture_decoder: RTL and testbench
=======================================

// Module: seg7_capture_decoder
// PURPOSE
//  Reverse path of the display driver: snoops the multiplexed 7-segment bus ({a,b,c,d,e,f,g,dp},
//  active-high, bit7=a, bit0=dp) plus per-digit strobes, and recovers per-digit BCD values.
//  Filters strobe/segment glitches with a stability counter, flags illegal patterns, and signals
//  when a full frame of digits has been captured. Sits between the display mux and self-check/readback logic.
// PARAMETERS
//  NUM_DIGITS     4  number of multiplexed digits (>=1)
//  STABLE_CYCLES  4  consecutive matching samples required before capture (>=1, <=255)
// PORTS
//  clk          in   1               system clock, rising edge
//  rst_n        in   1               asynchronous active-low reset
//  seg_in       in   8               segment bus {a,b,c,d,e,f,g,dp}, active-high
//  an_in        in   NUM_DIGITS      digit strobe, active-high, one-hot when a digit is driven
//  clr          in   1               synchronous clear of err, err_digit, digit_valid and frame mask
//  bcd_out      out  4*NUM_DIGITS    captured BCD digits, digit i at [4i+3:4i]
//  dp_out       out  NUM_DIGITS      captured decimal point per digit
//  digit_valid  out  NUM_DIGITS      1 = digit i holds a legal captured value
//  frame_valid  out  1               one-cycle pulse: every digit captured legally since last pulse/clr
//  err          out  1               sticky: illegal segment pattern seen
//  err_digit    out  clog2(NUM_DIGITS), min 1   index of most recent illegal digit
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0; internal seg_r/an_r, cnt, frame mask cleared.
//  - Each edge: match = ({seg_in,an_in}=={seg_r,an_r}) && an_in one-hot.
//    match -> cnt <= min(cnt+1, STABLE_CYCLES); else cnt <= 0. Always seg_r<=seg_in, an_r<=an_in.
//  - Capture on the edge where match && cnt==STABLE_CYCLES-1 (exactly once per stable window).
//    Inputs first sampled at edge k, held constant -> outputs update at edge k+STABLE_CYCLES.
//  - an_in all-zero or multi-hot (inter-digit blanking): cnt<=0, no capture, outputs hold.
//  - Decode seg_in[7:1] on capture for digit i = index of set an_in bit:
//    0:1111110 1:0110000 2:1101101 3:1111001 4:0110011 5:1011011 6:1011111 7:1110000
//    8:1111111 9:1111011.
//    Legal -> bcd_out[i]<=value, dp_out[i]<=seg_in[0], digit_valid[i]<=1, mask[i]<=1.
//    Blank (0000000) -> digit_valid[i]<=0, mask[i] unchanged, bcd/dp hold, no error.
//    Any other -> digit_valid[i]<=0, bcd/dp hold, err<=1, err_digit<=i.
//  - Frame: if capture makes mask all-ones, frame_valid=1 on that same edge and mask<=0.
//    frame_valid is 0 on all other cycles.
//  - clr: err, err_digit, digit_valid and mask <= 0 next edge. bcd_out/dp_out hold.
//    clr coinciding with a capture: clr wins for the cleared fields. bcd/dp still update if legal.
//    frame_valid is suppressed on that edge.
//  - Same digit recaptured (strobe reappears): new capture overwrites. No dedupe.
//  - rst_n asserted mid-window: immediate clear. Capture restarts from cnt=0 after release.
//  - Fully synchronous except rst_n. No combinational input-to-output path.
// TESTING
//  1 Reset: rst_n=0 mid-capture -> all outputs 0 immediately. cnt restarts after release.
//  2 Latency: an_in=0001, seg_in=8'b11110010 held from edge k (STABLE_CYCLES=4)
//    -> bcd_out[3:0]=3, digit_valid[0]=1 at edge k+4, not earlier.
//  3 Glitch: seg_in toggles 1 cycle at cycle 2 of window -> no capture. Capture 4 edges after glitch ends.
//  4 Frame: digits 0..3 driven with 1,2,3,4 (dp on digit 2)
//    -> bcd_out=16'h4321, dp_out=4'b0100, one frame_valid pulse on 4th capture.
//  5 Illegal: an_in=0100, seg_in=8'b10010000 -> err=1, err_digit=2, digit_valid[2]=0, bcd[11:8] held.
//    Then clr -> err=0.
//  6 Blanking/multi-hot: an_in=0000 or 0011 for 10 cycles -> no capture. Blank pattern -> no err.

Source files
------------

// File: rtl/seg7_capture_decoder.sv
// Snoops a multiplexed 7-segment bus and recovers per-digit BCD values.
// Glitches are filtered by a stability counter. Illegal patterns raise a sticky error.

module seg7_digit_slot (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cap_i,
    input  logic       legal_i,
    input  logic       clr_i,
    input  logic [3:0] val_i,
    input  logic       dp_i,
    output logic [3:0] bcd_o,
    output logic       dp_o,
    output logic       vld_o
);
    logic [3:0] bcd_q;
    logic       dp_q;
    logic       vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q <= 4'd0;
            dp_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            // Value and dp still land on a clr edge; only validity is cleared.
            if (cap_i && legal_i) begin
                bcd_q <= val_i;
                dp_q  <= dp_i;
            end
            if (clr_i)      vld_q <= 1'b0;
            else if (cap_i) vld_q <= legal_i;
        end
    end

    assign bcd_o = bcd_q;
    assign dp_o  = dp_q;
    assign vld_o = vld_q;
endmodule

module seg7_capture_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int IW            = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    err,
    output logic [IW-1:0]           err_digit
);
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    logic [7:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [7:0]            cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d, mask_nxt;
    logic                  err_q, err_d;
    logic [IW-1:0]         err_digit_q, err_digit_d;
    logic                  frame_q, frame_d;

    logic                  onehot, match, cap;
    logic [IW-1:0]         idx;
    logic                  dec_legal, dec_blank;
    logic [3:0]            dec_val;

    always_comb begin
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        dec_val   = 4'd0;
        case (seg_in[7:1])
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b1011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1111011: dec_val = 4'd9;
            7'b0000000: begin dec_legal = 1'b0; dec_blank = 1'b1; end
            default:    dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        onehot = (an_in != '0) && ((an_in & (an_in - ONE)) == '0);
        match  = ({seg_in, an_in} == {seg_q, an_q}) && onehot;
        // Saturating at CNT_MAX makes the capture fire exactly once per stable window.
        if (!match)                cnt_d = 8'd0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else                       cnt_d = cnt_q + 8'd1;
        cap = match && (cnt_q == CNT_MAX - 8'd1);
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (an_in[i]) idx = IW'(i);
    end

    always_comb begin
        mask_nxt    = mask_q | ((cap && dec_legal) ? an_in : '0);
        mask_d      = mask_nxt;
        frame_d     = 1'b0;
        err_d       = err_q;
        err_digit_d = err_digit_q;
        if (cap && !dec_legal && !dec_blank) begin
            err_d       = 1'b1;
            err_digit_d = idx;
        end
        if (clr) begin
            mask_d      = '0;
            err_d       = 1'b0;
            err_digit_d = '0;
        end else if (cap && dec_legal && (&mask_nxt)) begin
            mask_d  = '0;
            frame_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= 8'd0;
            an_q        <= '0;
            cnt_q       <= 8'd0;
            mask_q      <= '0;
            err_q       <= 1'b0;
            err_digit_q <= '0;
            frame_q     <= 1'b0;
        end else begin
            seg_q       <= seg_in;
            an_q        <= an_in;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            err_q       <= err_d;
            err_digit_q <= err_digit_d;
            frame_q     <= frame_d;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
        seg7_digit_slot u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .cap_i   (cap && an_in[g]),
            .legal_i (dec_legal),
            .clr_i   (clr),
            .val_i   (dec_val),
            .dp_i    (seg_in[0]),
            .bcd_o   (bcd_out[4*g +: 4]),
            .dp_o    (dp_out[g]),
            .vld_o   (digit_valid[g])
        );
    end

    assign frame_valid = frame_q;
    assign err         = err_q;
    assign err_digit   = err_digit_q;
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Scoreboard bench for seg7_capture_decoder (4 digits, 4-sample stability window).

module tb_seg7_capture_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seg_in = 8'd0;
    logic [3:0]  an_in = 4'd0;
    logic        clr = 1'b0;
    logic [15:0] bcd_out;
    logic [3:0]  dp_out, digit_valid;
    logic        frame_valid, err;
    logic [1:0]  err_digit;

    seg7_capture_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in), .clr(clr),
        .bcd_out(bcd_out), .dp_out(dp_out), .digit_valid(digit_valid),
        .frame_valid(frame_valid), .err(err), .err_digit(err_digit)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic [3:0]  vld;
        logic        err;
        logic [1:0]  ed;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0, n_fail = 0;
    int step_no = 0, fv_cnt = 0, fv_last = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        step_no++;
        if (frame_valid) begin
            fv_cnt++;
            fv_last = step_no;
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) step();
    endtask

    task automatic push(input string tag, input logic [15:0] bcd, input logic [3:0] dp,
                        input logic [3:0] vld, input logic e, input logic [1:0] ed);
        exp_t x;
        x.tag = tag; x.bcd = bcd; x.dp = dp; x.vld = vld; x.err = e; x.ed = ed;
        sb.push_back(x);
    endtask

    task automatic pop_check();
        exp_t x;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        x = sb.pop_front();
        chk({x.tag, "_bcd"}, 32'(bcd_out), 32'(x.bcd));
        chk({x.tag, "_dp"},  32'(dp_out), 32'(x.dp));
        chk({x.tag, "_vld"}, 32'(digit_valid), 32'(x.vld));
        chk({x.tag, "_err"}, 32'(err), 32'(x.err));
        chk({x.tag, "_ed"},  32'(err_digit), 32'(x.ed));
    endtask

    initial begin
        int base;
        // Reset state
        repeat (2) step();
        push("reset", 16'h0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        pop_check();
        chk("reset_fv", 32'(frame_valid), 32'd0);
        rst_n = 1'b1;

        // Latency: digit 0 shows 3, nothing before the 4th edge
        push("lat_early", 16'h0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        hold(4'b0001, 8'b11110010, 4);
        pop_check();
        push("lat", 16'h0003, 4'b0000, 4'b0001, 1'b0, 2'd0);
        step();
        pop_check();

        // Reset mid-window clears outputs immediately; window restarts after release
        hold(4'b0010, 8'b10110110, 2);
        rst_n = 1'b0;
        #1;
        push("rst_mid", 16'h0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        pop_check();
        repeat (2) step();
        rst_n = 1'b1;
        push("rst_early", 16'h0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        repeat (4) step();
        pop_check();
        push("rst_cap", 16'h0050, 4'b0000, 4'b0010, 1'b0, 2'd0);
        step();
        pop_check();

        // Single-cycle glitch restarts the window
        hold(4'b0001, 8'b11100000, 2);
        hold(4'b0001, 8'b11111110, 1);
        push("glitch_none", 16'h0050, 4'b0000, 4'b0010, 1'b0, 2'd0);
        hold(4'b0001, 8'b11100000, 4);
        pop_check();
        push("glitch_cap", 16'h0057, 4'b0000, 4'b0011, 1'b0, 2'd0);
        step();
        pop_check();

        // Frame: clear the mask, then capture 1,2,3.,4
        an_in = 4'b0000;
        clr = 1'b1;
        step();
        clr = 1'b0;
        fv_cnt = 0;
        hold(4'b0001, 8'b01100000, 5);
        hold(4'b0010, 8'b11011010, 5);
        hold(4'b0100, 8'b11110011, 5);
        chk("frame_pre", 32'(fv_cnt), 32'd0);
        base = step_no;
        hold(4'b1000, 8'b01100110, 5);
        chk("frame_cnt", 32'(fv_cnt), 32'd1);
        chk("frame_edge", 32'(fv_last), 32'(base + 5));
        push("frame", 16'h4321, 4'b0100, 4'b1111, 1'b0, 2'd0);
        pop_check();

        // Illegal pattern on digit 2, then clr
        hold(4'b0100, 8'b10010000, 5);
        push("illegal", 16'h4321, 4'b0100, 4'b1011, 1'b1, 2'd2);
        pop_check();
        an_in = 4'b0000;
        clr = 1'b1;
        step();
        clr = 1'b0;
        push("clr", 16'h4321, 4'b0100, 4'b0000, 1'b0, 2'd0);
        pop_check();

        // Blanking and multi-hot strobes never capture
        hold(4'b0000, 8'b11111110, 10);
        hold(4'b0011, 8'b11111110, 10);
        push("multihot", 16'h4321, 4'b0100, 4'b0000, 1'b0, 2'd0);
        pop_check();
        hold(4'b1000, 8'b11110110, 5);
        push("cap9", 16'h9321, 4'b0100, 4'b1000, 1'b0, 2'd0);
        pop_check();
        hold(4'b1000, 8'b00000000, 5);
        push("blank", 16'h9321, 4'b0100, 4'b0000, 1'b0, 2'd0);
        pop_check();

        // clr on the capture edge: value lands, validity cleared
        hold(4'b0001, 8'b10111110, 4);
        clr = 1'b1;
        step();
        clr = 1'b0;
        push("clr_cap", 16'h9326, 4'b0100, 4'b0000, 1'b0, 2'd0);
        pop_check();
        hold(4'b0000, 8'b00000000, 3);
        chk("fv_total", 32'(fv_cnt), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
